// File: rtl/axis_pattern_gen_m_axis.sv
// AXI-Stream master test-pattern source: framed packets with configurable length, gap and count,
// carrying a counter, LFSR, constant or walking-one pattern.
module axis_pattern_gen_m_axis #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_PKT_LEN_WIDTH      = 16,
  parameter int unsigned C_GAP_WIDTH          = 8
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  input  logic                                cfg_enable,
  input  logic [1:0]                          cfg_mode,
  input  logic [C_PKT_LEN_WIDTH-1:0]          cfg_pkt_len,
  input  logic [C_GAP_WIDTH-1:0]              cfg_gap,
  input  logic [15:0]                         cfg_num_pkts,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     cfg_const,
  output logic                                status_busy,
  output logic                                status_done,
  output logic [15:0]                         status_pkt_count,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int unsigned W    = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned LW   = C_PKT_LEN_WIDTH;
  localparam int unsigned GW   = C_GAP_WIDTH;
  localparam int unsigned REPL = W / 32;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  state_t          state_q, state_n;
  logic [LW-1:0]   beat_q, beat_n, len_m1_q, len_m1_n;
  logic [GW-1:0]   gap_q, gap_n, gap_cnt_q, gap_cnt_n;
  logic [15:0]     num_q, num_n, pkt_cnt_n, pkt_inc;
  logic [1:0]      mode_q, mode_n;
  logic [W-1:0]    const_q, const_n, cnt_q, cnt_n, walk_q, walk_n, tdata_n;
  logic [31:0]     lfsr_q, lfsr_n;
  logic            hs;

  assign M_AXIS_TSTRB = '1;
  assign hs           = M_AXIS_TVALID & M_AXIS_TREADY;
  assign pkt_inc      = status_pkt_count + 16'd1;

  // Next-state, config latch and pattern advance
  always_comb begin
    state_n   = state_q;
    beat_n    = beat_q;
    len_m1_n  = len_m1_q;
    gap_n     = gap_q;
    gap_cnt_n = gap_cnt_q;
    num_n     = num_q;
    mode_n    = mode_q;
    const_n   = const_q;
    cnt_n     = cnt_q;
    lfsr_n    = lfsr_q;
    walk_n    = walk_q;
    pkt_cnt_n = status_pkt_count;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          state_n   = ST_SEND;
          beat_n    = '0;
          len_m1_n  = (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - LW'(1);
          gap_n     = cfg_gap;
          num_n     = cfg_num_pkts;
          mode_n    = cfg_mode;
          const_n   = cfg_const;
          cnt_n     = '0;
          lfsr_n    = 32'h00000001;
          walk_n    = W'(1);
          pkt_cnt_n = '0;
        end
      end
      ST_SEND: begin
        if (hs) begin
          cnt_n  = cnt_q + W'(1);
          lfsr_n = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
          walk_n = {walk_q[W-2:0], walk_q[W-1]};
          if (M_AXIS_TLAST) begin
            beat_n    = '0;
            pkt_cnt_n = pkt_inc;
            if ((num_q != '0) && (pkt_inc == num_q)) begin
              state_n = ST_DONE;
            end else if (!cfg_enable) begin
              state_n = ST_IDLE;
            end else if (gap_q != '0) begin
              state_n   = ST_GAP;
              gap_cnt_n = gap_q;
            end
          end else begin
            beat_n = beat_q + LW'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= GW'(1)) begin
          state_n = cfg_enable ? ST_SEND : ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt_q - GW'(1);
        end
      end
      ST_DONE: begin
        if (!cfg_enable) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    case (mode_n)
      2'd0:    tdata_n = cnt_n;
      2'd1:    tdata_n = {REPL{lfsr_n}};
      2'd2:    tdata_n = const_n;
      default: tdata_n = walk_n;
    endcase
  end

  // State, pattern and registered outputs; all output values are derived from next state
  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      state_q          <= ST_IDLE;
      beat_q           <= '0;
      len_m1_q         <= '0;
      gap_q            <= '0;
      gap_cnt_q        <= '0;
      num_q            <= '0;
      mode_q           <= '0;
      const_q          <= '0;
      cnt_q            <= '0;
      lfsr_q           <= 32'h00000001;
      walk_q           <= W'(1);
      status_pkt_count <= '0;
      status_busy      <= 1'b0;
      status_done      <= 1'b0;
      M_AXIS_TVALID    <= 1'b0;
      M_AXIS_TDATA     <= '0;
      M_AXIS_TLAST     <= 1'b0;
    end else begin
      state_q          <= state_n;
      beat_q           <= beat_n;
      len_m1_q         <= len_m1_n;
      gap_q            <= gap_n;
      gap_cnt_q        <= gap_cnt_n;
      num_q            <= num_n;
      mode_q           <= mode_n;
      const_q          <= const_n;
      cnt_q            <= cnt_n;
      lfsr_q           <= lfsr_n;
      walk_q           <= walk_n;
      status_pkt_count <= pkt_cnt_n;
      status_busy      <= (state_n == ST_SEND) || (state_n == ST_GAP);
      status_done      <= (state_n == ST_DONE);
      M_AXIS_TVALID    <= (state_n == ST_SEND);
      M_AXIS_TDATA     <= tdata_n;
      M_AXIS_TLAST     <= (state_n == ST_SEND) && (beat_n == len_m1_n);
    end
  end

endmodule
